// File: rtl/scfifo_pkg.sv
// Shared constants and helpers for the SCFIFO drain stage.
package scfifo_pkg;

    // Legal range of the FIFO read latency, in clock cycles.
    localparam int unsigned ReadLatencyMin = 1;
    localparam int unsigned ReadLatencyMax = 3;

    // Width of a counter that must hold every value from 0 to depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Circular register buffer: push at the tail, pop from the head. The depth
// need not be a power of two. The head word is presented combinationally.
module stream_skid_buf
    import scfifo_pkg::*;
#(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 3
) (
    input  logic                         clock,
    input  logic                         aclr,
    input  logic                         sclr,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [cnt_width(DEPTH)-1:0]  count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             empty, full;
    logic             do_push, do_pop;

    // Pointer increment with wrap at DEPTH.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(DEPTH));

    // A pop needs a word; a push into a full buffer is only taken alongside a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Next pointers and occupancy; push+pop leaves the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Pointer and count registers; sclr clears them on the next edge.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (sclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; zeroed on aclr so the head reads 0 out of reset.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push && !sclr) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/scfifo_stream_drain.sv
// Drain stage for a normal-mode SCFIFO: issues reads under credit control,
// tracks the fixed read latency with a request shift register and lands the
// returning words in a skid buffer presented as a valid/ready stream.
module scfifo_stream_drain
    import scfifo_pkg::*;
#(
    parameter int unsigned WIDTH        = 20,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned BUF_DEPTH    = READ_LATENCY + 2
) (
    input  logic                             clock,
    input  logic                             aclr,
    input  logic                             sclr,
    input  logic [WIDTH-1:0]                 fifo_q,
    input  logic                             fifo_empty,
    output logic                             fifo_rdreq,
    output logic [WIDTH-1:0]                 out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [cnt_width(BUF_DEPTH)-1:0]  buf_count
);

    localparam int unsigned CntW = cnt_width(BUF_DEPTH);

    if (READ_LATENCY < ReadLatencyMin || READ_LATENCY > ReadLatencyMax) begin : g_bad_latency
        $error("scfifo_stream_drain: READ_LATENCY %0d outside %0d..%0d",
               READ_LATENCY, ReadLatencyMin, ReadLatencyMax);
    end

    if (BUF_DEPTH < READ_LATENCY + 2) begin : g_bad_depth
        $error("scfifo_stream_drain: BUF_DEPTH %0d below READ_LATENCY+2", BUF_DEPTH);
    end

    // Bit i set means a read issued i+1 cycles ago; the top bit marks data on fifo_q now.
    logic [READ_LATENCY-1:0] req_sr_q, req_sr_d;
    logic [READ_LATENCY:0]   req_sr_ext;
    logic [CntW-1:0]         inflight;
    logic [CntW:0]           credit_used;
    logic                    push;

    assign req_sr_ext = {req_sr_q, fifo_rdreq};
    assign req_sr_d   = req_sr_ext[READ_LATENCY-1:0];
    assign push       = req_sr_q[READ_LATENCY-1];

    // Reads still on their way back from the FIFO.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CntW'(req_sr_q[i]);
        end
    end

    // Credit check on registered state only, so out_ready has no path to fifo_rdreq.
    always_comb begin
        credit_used = {1'b0, buf_count} + {1'b0, inflight};
        fifo_rdreq  = !aclr && !sclr && !fifo_empty &&
                      (credit_used < (CntW + 1)'(BUF_DEPTH));
    end

    // Request shift register; clearing it drops data for reads issued before a clear.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            req_sr_q <= '0;
        end else if (sclr) begin
            req_sr_q <= '0;
        end else begin
            req_sr_q <= req_sr_d;
        end
    end

    stream_skid_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_skid_buf (
        .clock     (clock),
        .aclr      (aclr),
        .sclr      (sclr),
        .push      (push),
        .push_data (fifo_q),
        .pop       (out_ready),
        .head_data (out_data),
        .count     (buf_count)
    );

    assign out_valid = (buf_count != '0);

endmodule

// File: tb/tb_scfifo_stream_drain.sv
// Bench: three drain instances (READ_LATENCY 1, 2, 3) share clock, clears and
// out_ready; each has its own behavioural FIFO and an in-order scoreboard.
module tb_scfifo_stream_drain;

    localparam int unsigned W     = 20;
    localparam int          NL    = 3;
    localparam int          MemSz = 1100;

    typedef struct {
        logic ready;
        logic exp_rdreq;
        logic exp_valid;
        int   exp_cnt;
        int   exp_idx;   // -1: data not checked
    } vec_t;

    logic          clk = 1'b0;
    logic          aclr, sclr, out_ready;
    logic [W-1:0]  dl [NL][3];
    logic [NL-1:0] fifo_empty, rdreq_v, valid_v;
    logic [W-1:0]  data_v [NL];
    logic [2:0]    cnt_v [NL];

    logic [W-1:0]  mem [NL][MemSz];
    int            wr_n [NL];
    int            rd_n [NL];
    logic [W-1:0]  exp_q [NL][$];
    int            delivered [NL];
    logic          hold [NL];
    logic [W-1:0]  hold_data [NL];
    logic          s_rdreq [NL];
    logic          s_valid [NL];
    int            s_cnt [NL];
    logic [W-1:0]  s_data [NL];
    int            n_tests = 0;
    int            n_fail = 0;
    vec_t          bp_tbl [12];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int unsigned RL = g + 1;
        localparam int unsigned D  = RL + 2;
        logic [$clog2(D + 1)-1:0] cnt;
        assign fifo_empty[g] = (rd_n[g] == wr_n[g]);
        assign cnt_v[g]      = 3'(cnt);
        scfifo_stream_drain #(
            .WIDTH        (W),
            .READ_LATENCY (RL),
            .BUF_DEPTH    (D)
        ) u_dut (
            .clock      (clk),
            .aclr       (aclr),
            .sclr       (sclr),
            .fifo_q     (dl[g][RL-1]),
            .fifo_empty (fifo_empty[g]),
            .fifo_rdreq (rdreq_v[g]),
            .out_data   (data_v[g]),
            .out_valid  (valid_v[g]),
            .out_ready  (out_ready),
            .buf_count  (cnt)
        );
    end

    function automatic int lat(input int l);
        return l + 1;
    endfunction

    function automatic int depth(input int l);
        return l + 3;
    endfunction

    task automatic chk(input string name, input int l, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s lane%0d: got 0x%0h, want 0x%0h", name, l, act, req);
        end
    endtask

    function automatic logic all_done();
        for (int l = 0; l < NL; l++) begin
            if (exp_q[l].size() != 0 || rd_n[l] != wr_n[l]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic load(input int n, input int base, input logic rnd);
        for (int l = 0; l < NL; l++) begin
            for (int i = 0; i < n; i++) begin
                mem[l][wr_n[l] + i] = rnd ? W'($urandom) : W'(base + i);
            end
            wr_n[l] += n;
        end
    endtask

    task automatic reset_model();
        for (int l = 0; l < NL; l++) begin
            rd_n[l]      = 0;
            wr_n[l]      = 0;
            delivered[l] = 0;
        end
    endtask

    // One clock: sample and score at the falling edge, advance the FIFO model after the rise.
    task automatic tick();
        logic [W-1:0] word [NL];
        logic         clr;
        @(negedge clk);
        clr = aclr || sclr;
        for (int l = 0; l < NL; l++) begin
            s_rdreq[l] = rdreq_v[l];
            s_valid[l] = valid_v[l];
            s_cnt[l]   = int'(cnt_v[l]);
            s_data[l]  = data_v[l];
            word[l]    = '0;
            if (s_rdreq[l]) begin
                chk("rdreq_while_empty", l, int'(fifo_empty[l]), 0);
                chk("rdreq_during_clear", l, int'(clr), 0);
                word[l] = mem[l][rd_n[l]];
            end
            chk("count_bound", l, int'(s_cnt[l] <= depth(l)), 1);
            chk("valid_vs_count", l, int'(s_valid[l]), int'(s_cnt[l] != 0));
            if (hold[l] && s_valid[l] && !clr) begin
                chk("hold_stable", l, int'(s_data[l]), int'(hold_data[l]));
            end
            if (s_valid[l] && out_ready && !clr) begin
                n_tests++;
                if (exp_q[l].size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_beat lane%0d: got data 0x%0h, want no beat", l, s_data[l]);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q[l].pop_front();
                    if (s_data[l] != e) begin
                        n_fail++;
                        $display("FAIL beat_data lane%0d: got 0x%0h, want 0x%0h", l, s_data[l], e);
                    end
                    delivered[l]++;
                end
            end
            hold[l]      = s_valid[l] && !out_ready;
            hold_data[l] = s_data[l];
        end
        @(posedge clk);
        #1;
        for (int l = 0; l < NL; l++) begin
            for (int k = 2; k > 0; k--) dl[l][k] = dl[l][k-1];
            dl[l][0] = s_rdreq[l] ? word[l] : W'($urandom);
            if (s_rdreq[l]) begin
                exp_q[l].push_back(word[l]);
                rd_n[l]++;
            end
            if (clr) begin
                exp_q[l].delete();
                hold[l] = 1'b0;
                rd_n[l] = wr_n[l];
            end
        end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        out_ready = 1'b1;
        while (!all_done() && k < budget) begin
            tick();
            k++;
        end
        n_tests++;
        if (!all_done()) begin
            n_fail++;
            $display("FAIL drain_timeout: got words pending after %0d cycles, want none", budget);
        end
        repeat (5) tick();
        for (int l = 0; l < NL; l++) begin
            chk("drain_valid", l, int'(s_valid[l]), 0);
            chk("drain_count", l, s_cnt[l], 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first [NL];
        int last [NL];
        int beats [NL];
        int rq_n [NL];
        int k;

        aclr      = 1'b1;
        sclr      = 1'b0;
        out_ready = 1'b0;
        for (int l = 0; l < NL; l++) begin
            hold[l] = 1'b0;
            for (int j = 0; j < 3; j++) dl[l][j] = '0;
        end
        reset_model();

        // Reset and idle with the FIFO empty.
        #1;
        for (int l = 0; l < NL; l++) begin
            chk("reset_rdreq", l, int'(rdreq_v[l]), 0);
            chk("reset_valid", l, int'(valid_v[l]), 0);
            chk("reset_count", l, int'(cnt_v[l]), 0);
            chk("reset_data", l, int'(data_v[l]), 0);
        end
        tick();
        tick();
        aclr = 1'b0;
        repeat (20) begin
            tick();
            for (int l = 0; l < NL; l++) begin
                chk("idle_rdreq", l, int'(s_rdreq[l]), 0);
                chk("idle_valid", l, int'(s_valid[l]), 0);
                chk("idle_count", l, s_cnt[l], 0);
            end
        end

        // Streaming 0x00001..0x00040 with the consumer always ready.
        out_ready = 1'b1;
        load(64, 'h00001, 1'b0);
        for (int l = 0; l < NL; l++) begin
            first[l] = -1;
            last[l]  = -1;
            beats[l] = 0;
        end
        for (int c = 0; c < 80; c++) begin
            tick();
            for (int l = 0; l < NL; l++) begin
                if (s_valid[l]) begin
                    if (first[l] < 0) first[l] = c;
                    last[l] = c;
                    beats[l]++;
                end
            end
        end
        for (int l = 0; l < NL; l++) begin
            chk("fill_latency", l, first[l], lat(l) + 1);
            chk("stream_beats", l, beats[l], 64);
            chk("stream_no_gaps", l, last[l] - first[l], 63);
            chk("stream_delivered", l, delivered[l], 64);
        end
        drain(200);
        reset_model();

        // Backpressure: cycle-by-cycle vectors for the READ_LATENCY=2 lane.
        bp_tbl[0]  = '{1'b0, 1'b1, 1'b0, 0, -1};
        bp_tbl[1]  = '{1'b0, 1'b1, 1'b0, 0, -1};
        bp_tbl[2]  = '{1'b0, 1'b1, 1'b0, 0, -1};
        bp_tbl[3]  = '{1'b0, 1'b1, 1'b1, 1, 0};
        bp_tbl[4]  = '{1'b0, 1'b0, 1'b1, 2, 0};
        bp_tbl[5]  = '{1'b0, 1'b0, 1'b1, 3, 0};
        bp_tbl[6]  = '{1'b0, 1'b0, 1'b1, 4, 0};
        bp_tbl[7]  = '{1'b0, 1'b0, 1'b1, 4, 0};
        bp_tbl[8]  = '{1'b1, 1'b0, 1'b1, 4, 0};
        bp_tbl[9]  = '{1'b1, 1'b1, 1'b1, 3, 1};
        bp_tbl[10] = '{1'b1, 1'b1, 1'b1, 2, 2};
        bp_tbl[11] = '{1'b1, 1'b1, 1'b1, 1, 3};
        out_ready = 1'b0;
        load(10, 'hB0000, 1'b0);
        for (int l = 0; l < NL; l++) rq_n[l] = 0;
        for (int r = 0; r < 12; r++) begin
            out_ready = bp_tbl[r].ready;
            tick();
            chk($sformatf("bp_rdreq_r%0d", r), 1, int'(s_rdreq[1]), int'(bp_tbl[r].exp_rdreq));
            chk($sformatf("bp_valid_r%0d", r), 1, int'(s_valid[1]), int'(bp_tbl[r].exp_valid));
            chk($sformatf("bp_count_r%0d", r), 1, s_cnt[1], bp_tbl[r].exp_cnt);
            if (bp_tbl[r].exp_idx >= 0) begin
                chk($sformatf("bp_data_r%0d", r), 1, int'(s_data[1]),
                    'hB0000 + bp_tbl[r].exp_idx);
            end
            if (r < 8) begin
                for (int l = 0; l < NL; l++) rq_n[l] += int'(s_rdreq[l]);
            end
        end
        for (int l = 0; l < NL; l++) chk("bp_total_rdreq", l, rq_n[l], depth(l));
        drain(300);
        for (int l = 0; l < NL; l++) chk("bp_delivered", l, delivered[l], 10);
        reset_model();

        // Random 50% ready over 1000 random words.
        load(1000, 0, 1'b1);
        k = 0;
        while (!all_done() && k < 6000) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        drain(100);
        for (int l = 0; l < NL; l++) chk("rand_delivered", l, delivered[l], 1000);
        reset_model();

        // Synchronous clear with two reads in flight.
        out_ready = 1'b0;
        load(10, 'hC0000, 1'b0);
        tick();
        tick();
        for (int l = 0; l < NL; l++) chk("sclr_setup_rdreq", l, int'(s_rdreq[l]), 1);
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        tick();
        for (int l = 0; l < NL; l++) begin
            chk("sclr_valid", l, int'(s_valid[l]), 0);
            chk("sclr_count", l, s_cnt[l], 0);
        end
        out_ready = 1'b1;
        repeat (6) begin
            tick();
            for (int l = 0; l < NL; l++) chk("sclr_no_return", l, int'(s_valid[l]), 0);
        end
        reset_model();

        // Asynchronous clear between edges while lane 0 holds 3 words.
        out_ready = 1'b0;
        load(10, 'hD0000, 1'b0);
        repeat (12) tick();
        chk("aclr_setup_count", 0, s_cnt[0], 3);
        #2;
        aclr = 1'b1;
        #1;
        for (int l = 0; l < NL; l++) begin
            chk("aclr_now_valid", l, int'(valid_v[l]), 0);
            chk("aclr_now_count", l, int'(cnt_v[l]), 0);
            chk("aclr_now_rdreq", l, int'(rdreq_v[l]), 0);
            chk("aclr_now_data", l, int'(data_v[l]), 0);
        end
        tick();
        aclr = 1'b0;
        reset_model();
        load(8, 'hE0000, 1'b0);
        out_ready = 1'b1;
        tick();
        for (int l = 0; l < NL; l++) chk("aclr_resume_rdreq", l, int'(s_rdreq[l]), 1);
        drain(100);
        for (int l = 0; l < NL; l++) chk("aclr_refill_delivered", l, delivered[l], 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
